// File: rtl/deconcatenator.sv
// Splits a framed byte stream into a byte stream and two LSB-first packed word streams.
// Optional frame-alignment checking on i_in_last: define DECONCATENATOR_FRAME_CHECK_EN.
module deconcatenator #(
  parameter int WIDTH1  = 8,
  parameter int WIDTH2  = 96,
  parameter int WIDTH3  = 96,
  parameter int LENGTH1 = 144,
  parameter int LENGTH2 = 12,
  parameter int LENGTH3 = 132
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [WIDTH1-1:0] i_in_data,
  input  logic              i_in_valid,
  input  logic              i_in_last,
  output logic              o_in_ready,
  output logic [WIDTH1-1:0] o_first_data,
  output logic              o_first_valid,
  input  logic              i_first_ready,
  output logic [WIDTH2-1:0] o_second_data,
  output logic              o_second_valid,
  input  logic              i_second_ready,
  output logic [WIDTH3-1:0] o_third_data,
  output logic              o_third_valid,
  input  logic              i_third_ready,
  output logic              o_frame_error
);

  localparam int SUB2    = WIDTH2 / WIDTH1;
  localparam int SUB3    = WIDTH3 / WIDTH1;
  localparam int MAXLEN  = (LENGTH1 > LENGTH2) ? ((LENGTH1 > LENGTH3) ? LENGTH1 : LENGTH3)
                                               : ((LENGTH2 > LENGTH3) ? LENGTH2 : LENGTH3);
  localparam int MAXSUB  = (SUB2 > SUB3) ? SUB2 : SUB3;
  localparam int CW      = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int SW      = (MAXSUB > 1) ? $clog2(MAXSUB) : 1;
  localparam int PW      = (WIDTH2 > WIDTH3) ? WIDTH2 : WIDTH3;

  typedef enum logic [1:0] {
    ST_FIRST,
    ST_SECOND,
    ST_THIRD
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     seg_cnt_reg, seg_cnt_next;
  logic [SW-1:0]     sub_cnt_reg, sub_cnt_next;
  logic [PW-1:0]     pack_reg, pack_next;
  logic [WIDTH1-1:0] first_data_reg, first_data_next;
  logic              first_valid_reg, first_valid_next;
  logic [WIDTH2-1:0] second_data_reg, second_data_next;
  logic              second_valid_reg, second_valid_next;
  logic [WIDTH3-1:0] third_data_reg, third_data_next;
  logic              third_valid_reg, third_valid_next;

  logic [WIDTH2-1:0] word2;
  logic [WIDTH3-1:0] word3;
  logic              first_free, second_free, third_free;
  logic              last_sub, seg_end, ready_state, accept;

  // Completed word: newest byte on top, earlier bytes already shifted toward bit 0.
  if (SUB2 == 1) begin : g_word2_single
    assign word2 = i_in_data;
  end else begin : g_word2_pack
    assign word2 = {i_in_data, pack_reg[WIDTH2-1:WIDTH1]};
  end

  if (SUB3 == 1) begin : g_word3_single
    assign word3 = i_in_data;
  end else begin : g_word3_pack
    assign word3 = {i_in_data, pack_reg[WIDTH3-1:WIDTH1]};
  end

  // The lowest byte of the pack register is always shifted out before it is read.
  logic unused_pack_lsb;
  assign unused_pack_lsb = ^pack_reg[WIDTH1-1:0];

  assign first_free  = !first_valid_reg  || i_first_ready;
  assign second_free = !second_valid_reg || i_second_ready;
  assign third_free  = !third_valid_reg  || i_third_ready;

  assign last_sub = ((state_reg == ST_SECOND) && (sub_cnt_reg == SW'(SUB2 - 1))) ||
                    ((state_reg == ST_THIRD)  && (sub_cnt_reg == SW'(SUB3 - 1)));
  assign seg_end  = (seg_cnt_reg == '0);

  always_comb begin
    ready_state = 1'b0;
    case (state_reg)
      ST_FIRST:  ready_state = first_free;
      ST_SECOND: ready_state = !last_sub || second_free;
      ST_THIRD:  ready_state = !last_sub || third_free;
      default:   ready_state = 1'b0;
    endcase
  end

  assign o_in_ready = !i_reset && ready_state;
  assign accept     = i_in_valid && o_in_ready;

`ifdef DECONCATENATOR_FRAME_CHECK_EN
  logic frame_error_reg, frame_error_next;
  logic frame_final;
  assign frame_final   = (state_reg == ST_THIRD) && seg_end;
  assign o_frame_error = frame_error_reg;
`else
  logic unused_in_last;
  assign unused_in_last = i_in_last;
  assign o_frame_error  = 1'b0;
`endif

  always_comb begin
    state_next        = state_reg;
    seg_cnt_next      = seg_cnt_reg;
    sub_cnt_next      = sub_cnt_reg;
    pack_next         = pack_reg;
    first_data_next   = first_data_reg;
    second_data_next  = second_data_reg;
    third_data_next   = third_data_reg;
    // Drain happens first; a load in the same cycle overrides it below.
    first_valid_next  = first_valid_reg  && !i_first_ready;
    second_valid_next = second_valid_reg && !i_second_ready;
    third_valid_next  = third_valid_reg  && !i_third_ready;
`ifdef DECONCATENATOR_FRAME_CHECK_EN
    frame_error_next  = 1'b0;
`endif

    if (accept) begin
      case (state_reg)
        ST_FIRST: begin
          first_data_next  = i_in_data;
          first_valid_next = 1'b1;
          if (seg_end) begin
            state_next   = ST_SECOND;
            seg_cnt_next = CW'(LENGTH2 - 1);
          end else begin
            seg_cnt_next = seg_cnt_reg - CW'(1);
          end
        end
        ST_SECOND: begin
          pack_next = PW'(word2);
          if (last_sub) begin
            second_data_next  = word2;
            second_valid_next = 1'b1;
            sub_cnt_next      = '0;
          end else begin
            sub_cnt_next = sub_cnt_reg + SW'(1);
          end
          if (seg_end) begin
            state_next   = ST_THIRD;
            seg_cnt_next = CW'(LENGTH3 - 1);
            sub_cnt_next = '0;
          end else begin
            seg_cnt_next = seg_cnt_reg - CW'(1);
          end
        end
        ST_THIRD: begin
          pack_next = PW'(word3);
          if (last_sub) begin
            third_data_next  = word3;
            third_valid_next = 1'b1;
            sub_cnt_next     = '0;
          end else begin
            sub_cnt_next = sub_cnt_reg + SW'(1);
          end
          if (seg_end) begin
            state_next   = ST_FIRST;
            seg_cnt_next = CW'(LENGTH1 - 1);
            sub_cnt_next = '0;
          end else begin
            seg_cnt_next = seg_cnt_reg - CW'(1);
          end
        end
        default: begin
          state_next   = ST_FIRST;
          seg_cnt_next = CW'(LENGTH1 - 1);
          sub_cnt_next = '0;
        end
      endcase

`ifdef DECONCATENATOR_FRAME_CHECK_EN
      // Early last: the byte is still routed, then framing restarts at byte 0.
      if (i_in_last && !frame_final) begin
        frame_error_next = 1'b1;
        state_next       = ST_FIRST;
        seg_cnt_next     = CW'(LENGTH1 - 1);
        sub_cnt_next     = '0;
        pack_next        = '0;
      end else if (frame_final && !i_in_last) begin
        frame_error_next = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg        <= ST_FIRST;
      seg_cnt_reg      <= CW'(LENGTH1 - 1);
      sub_cnt_reg      <= '0;
      pack_reg         <= '0;
      first_data_reg   <= '0;
      first_valid_reg  <= 1'b0;
      second_data_reg  <= '0;
      second_valid_reg <= 1'b0;
      third_data_reg   <= '0;
      third_valid_reg  <= 1'b0;
`ifdef DECONCATENATOR_FRAME_CHECK_EN
      frame_error_reg  <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      seg_cnt_reg      <= seg_cnt_next;
      sub_cnt_reg      <= sub_cnt_next;
      pack_reg         <= pack_next;
      first_data_reg   <= first_data_next;
      first_valid_reg  <= first_valid_next;
      second_data_reg  <= second_data_next;
      second_valid_reg <= second_valid_next;
      third_data_reg   <= third_data_next;
      third_valid_reg  <= third_valid_next;
`ifdef DECONCATENATOR_FRAME_CHECK_EN
      frame_error_reg  <= frame_error_next;
`endif
    end
  end

  assign o_first_data   = first_data_reg;
  assign o_first_valid  = first_valid_reg;
  assign o_second_data  = second_data_reg;
  assign o_second_valid = second_valid_reg;
  assign o_third_data   = third_data_reg;
  assign o_third_valid  = third_valid_reg;

endmodule

// File: tb/tb_deconcatenator.sv
// Self-checking bench for deconcatenator: directed steps plus random traffic against a
// frame-position reference model (position within frame decides routing and packing).
module tb_deconcatenator;
  localparam int L1 = 144;
  localparam int L2 = 12;
  localparam int L3 = 132;
  localparam int FRAME = L1 + L2 + L3;
  localparam int BPW = 12;  // bytes per packed word

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        first_ready = 1'b1;
  logic        second_ready = 1'b1;
  logic        third_ready = 1'b1;
  logic        o_in_ready;
  logic [7:0]  o_first_data;
  logic        o_first_valid;
  logic [95:0] o_second_data;
  logic        o_second_valid;
  logic [95:0] o_third_data;
  logic        o_third_valid;
  logic        o_frame_error;

  always #5 clk = ~clk;

  deconcatenator dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_in_data      (in_data),
    .i_in_valid     (in_valid),
    .i_in_last      (in_last),
    .o_in_ready     (o_in_ready),
    .o_first_data   (o_first_data),
    .o_first_valid  (o_first_valid),
    .i_first_ready  (first_ready),
    .o_second_data  (o_second_data),
    .o_second_valid (o_second_valid),
    .i_second_ready (second_ready),
    .o_third_data   (o_third_data),
    .o_third_valid  (o_third_valid),
    .i_third_ready  (third_ready),
    .o_frame_error  (o_frame_error)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference model state
  logic [7:0]  exp_first[$];
  logic [95:0] exp_second[$];
  logic [95:0] exp_third[$];
  int          pos = 0;
  logic [95:0] acc2 = '0, acc3 = '0;
  int          n2 = 0, n3 = 0;
  bit          err_exp = 1'b0;
  // Observation log
  logic [7:0]  first_log[$];
  int          second_cnt = 0, third_cnt = 0, err_cnt = 0;
  logic [95:0] last_second = '0, first_third = '0, last_third = '0;
  bit          hold_f = 0, hold_s = 0, hold_t = 0;
  logic [7:0]  held_f = '0;
  logic [95:0] held_s = '0, held_t = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_first.delete(); exp_second.delete(); exp_third.delete(); first_log.delete();
      pos = 0; acc2 = '0; acc3 = '0; n2 = 0; n3 = 0; err_exp = 1'b0;
      second_cnt = 0; third_cnt = 0; err_cnt = 0;
      hold_f = 0; hold_s = 0; hold_t = 0;
    end else begin
      chk("frame_error", o_frame_error, err_exp);
      if (o_frame_error) err_cnt++;
      err_exp = 1'b0;

      if (hold_f) chk("first_hold", {o_first_valid, o_first_data}, {1'b1, held_f});
      if (hold_s) chk("second_hold", {o_second_valid, o_second_data}, {1'b1, held_s});
      if (hold_t) chk("third_hold", {o_third_valid, o_third_data}, {1'b1, held_t});
      hold_f = o_first_valid && !first_ready;   held_f = o_first_data;
      hold_s = o_second_valid && !second_ready; held_s = o_second_data;
      hold_t = o_third_valid && !third_ready;   held_t = o_third_data;

      if (o_first_valid && first_ready) begin
        chk("first_expected", exp_first.size() != 0, 1);
        if (exp_first.size() != 0) chk("first_data", o_first_data, exp_first.pop_front());
        first_log.push_back(o_first_data);
      end
      if (o_second_valid && second_ready) begin
        chk("second_expected", exp_second.size() != 0, 1);
        if (exp_second.size() != 0) chk("second_data", o_second_data, exp_second.pop_front());
        last_second = o_second_data;
        second_cnt++;
      end
      if (o_third_valid && third_ready) begin
        chk("third_expected", exp_third.size() != 0, 1);
        if (exp_third.size() != 0) chk("third_data", o_third_data, exp_third.pop_front());
        if (third_cnt == 0) first_third = o_third_data;
        last_third = o_third_data;
        third_cnt++;
      end

      if (in_valid && o_in_ready) begin
        if (pos < L1) begin
          exp_first.push_back(in_data);
        end else if (pos < L1 + L2) begin
          acc2 |= 96'(in_data) << (8 * n2);
          n2++;
          if (n2 == BPW) begin exp_second.push_back(acc2); acc2 = '0; n2 = 0; end
        end else begin
          acc3 |= 96'(in_data) << (8 * n3);
          n3++;
          if (n3 == BPW) begin exp_third.push_back(acc3); acc3 = '0; n3 = 0; end
        end
`ifdef DECONCATENATOR_FRAME_CHECK_EN
        if (in_last && pos != FRAME - 1) begin
          err_exp = 1'b1; pos = 0; acc2 = '0; acc3 = '0; n2 = 0; n3 = 0;
        end else begin
          if (pos == FRAME - 1 && !in_last) err_exp = 1'b1;
          pos = (pos + 1) % FRAME;
        end
`else
        pos = (pos + 1) % FRAME;
`endif
      end
    end
  end

  // Called and returns at posedge+1
  task automatic send(input logic [7:0] b, input bit last, input bit expect_ready);
    bit ok = 0;
    in_data = b; in_last = last; in_valid = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (n == 0 && expect_ready) chk("in_ready_sustained", o_in_ready, 1);
      if (o_in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("in_ready_timeout", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    first_ready = 1; second_ready = 1; third_ready = 1;
    repeat (20) begin @(posedge clk); #1; end
    chk("queues_empty", exp_first.size() + exp_second.size() + exp_third.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0;
    bit done;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_valids", {o_first_valid, o_second_valid, o_third_valid}, 3'b000);
    chk("rst_data", {o_first_data, o_second_data, o_third_data}, '0);
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_frame_error", o_frame_error, 0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;

    // One frame of k mod 256 with all readies high
    for (int k = 0; k < FRAME; k++) send(8'(k), k == FRAME - 1, 1);
    drain();
    chk("t1_first_count", first_log.size(), L1);
    if (first_log.size() == L1) chk("t1_first_last", first_log[L1-1], 8'h8F);
    chk("t1_second_count", second_cnt, 1);
    chk("t1_second_word", last_second, 96'h9B9A99989796959493929190);
    chk("t1_third_count", third_cnt, 11);
    chk("t1_third_first", first_third, 96'hA7A6A5A4A3A2A1A09F9E9D9C);
    chk("t1_third_last", last_third, 96'h1F1E1D1C1B1A191817161514);

    // First consumer stalled from reset
    first_ready = 0;
    do_reset();
    send(8'h00, 0, 1);
    in_data = 8'h01; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t2_stall_ready", o_in_ready, 0);
      chk("t2_stall_valid", o_first_valid, 1);
      chk("t2_stall_data", o_first_data, 8'h00);
    end
    @(posedge clk); #1;
    first_ready = 1;
    for (int k = 1; k < 6; k++) send(8'(k), 0, 1);
    drain();
    chk("t2_first_count", first_log.size(), 6);

    // Two back-to-back frames, random gaps and random readies
    do_reset();
    done = 0; b0 = '0;
    fork
      begin
        for (int f = 0; f < 2; f++) begin
          for (int k = 0; k < FRAME; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (f == 1 && k == 0) b0 = b;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(b, k == FRAME - 1, 0);
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          first_ready  = ($urandom_range(0, 3) != 0);
          second_ready = ($urandom_range(0, 3) != 0);
          third_ready  = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    chk("t3_first_count", first_log.size(), 2 * L1);
    if (first_log.size() > L1) chk("t3_frame2_byte0", first_log[L1], b0);
    chk("t3_second_count", second_cnt, 2);
    chk("t3_third_count", third_cnt, 22);

    // Asynchronous reset after 200 bytes
    do_reset();
    for (int k = 0; k < 200; k++) send(8'(k), 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("t4_valids_cleared", {o_first_valid, o_second_valid, o_third_valid}, 3'b000);
    chk("t4_ready_in_reset", o_in_ready, 0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    send(8'hAA, 0, 1);
    drain();
    chk("t4_first_count", first_log.size(), 1);
    if (first_log.size() == 1) chk("t4_first_byte", first_log[0], 8'hAA);
    chk("t4_other_counts", second_cnt + third_cnt, 0);

    // i_in_last on byte 99
    do_reset();
    for (int k = 0; k < 100; k++) send(8'(k), k == 99, 1);
    for (int k = 100; k < 250; k++) send(8'(k), 0, 1);
    drain();
`ifdef DECONCATENATOR_FRAME_CHECK_EN
    chk("t5_err_pulses", err_cnt, 1);
    chk("t5_first_count", first_log.size(), 244);
    if (first_log.size() > 100) chk("t5_resync_byte", first_log[100], 8'd100);
    chk("t5_second_count", second_cnt, 0);
`else
    chk("t5_err_pulses", err_cnt, 0);
    chk("t5_first_count", first_log.size(), L1);
    chk("t5_second_count", second_cnt, 1);
    chk("t5_third_count", third_cnt, 7);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
